demux_stream: RTL

Registered 1-to-2 demultiplexer with valid/ready handshakes. It steers each W-bit input word to output port X or port Y according to `sel_in`, and is the distribution counterpart of the datapath `mux` selector. Each output has a one-entry holding register, so words are stored until the downstream consumer accepts them. Per-port delivered-word counters support debug and verification.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_slot.sv | 59 +++++
 rtl/demux_stream.sv | 66 ++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-2 stream demultiplexer.
package demux_pkg;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One output port of the demux: a one-entry holding register, its EMPTY/FULL state and a
// wrapping count of words handed to the consumer.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fill_i,
  input  logic [W-1:0]     fill_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             can_accept_o
);

  slot_state_e      state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    drain   = (state_q == SLOT_FULL) && ready_i;
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      SLOT_EMPTY: if (fill_i) state_d = SLOT_FULL;
      // A simultaneous drain and fill keeps the slot FULL, so there is no bubble.
      SLOT_FULL:  if (drain && !fill_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    if (fill_i) data_d = fill_data_i;
    if (drain) count_d = count_q + CNT_W'(1);
  end

  always_comb begin
    valid_o      = (state_q == SLOT_FULL);
    data_o       = data_q;
    count_o      = count_q;
    can_accept_o = (state_q == SLOT_EMPTY) || ready_i;
  end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-2 stream demultiplexer: steers each input word to port X or Y by sel_in,
// with an independent one-entry holding slot per port.
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     A_in,
  input  logic             valid_in,
  input  logic             sel_in,
  output logic             ready_out,
  output logic [W-1:0]     X_out,
  output logic             X_valid_out,
  input  logic             X_ready_in,
  output logic [W-1:0]     Y_out,
  output logic             Y_valid_out,
  input  logic             Y_ready_in,
  output logic [CNT_W-1:0] X_count_out,
  output logic [CNT_W-1:0] Y_count_out
);

  logic x_can_accept, y_can_accept;
  logic accept, x_fill, y_fill;

  // Only the selected port gates ready, so a stalled port never blocks the other.
  always_comb begin
    ready_out = !reset && ((sel_in == SEL_Y) ? y_can_accept : x_can_accept);
    accept    = valid_in && ready_out;
    x_fill    = accept && (sel_in == SEL_X);
    y_fill    = accept && (sel_in == SEL_Y);
  end

  demux_slot #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_slot_x (
    .clk_i        (clk),
    .rst_i        (reset),
    .fill_i       (x_fill),
    .fill_data_i  (A_in),
    .ready_i      (X_ready_in),
    .valid_o      (X_valid_out),
    .data_o       (X_out),
    .count_o      (X_count_out),
    .can_accept_o (x_can_accept)
  );

  demux_slot #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_slot_y (
    .clk_i        (clk),
    .rst_i        (reset),
    .fill_i       (y_fill),
    .fill_data_i  (A_in),
    .ready_i      (Y_ready_in),
    .valid_o      (Y_valid_out),
    .data_o       (Y_out),
    .count_o      (Y_count_out),
    .can_accept_o (y_can_accept)
  );

endmodule
